// File: rtl/core_uart_frame_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// core_uart_frame_rx : SOF/LEN/payload/CHK frame receiver behind CoreUART.
// Optional inter-byte timeout: define CORE_UART_FRAME_TIMEOUT_EN.  Rev 1.0
//------------------------------------------------------------------------------
module core_uart_frame_rx #(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        uart_rxrdy,
  input  logic [7:0]  uart_data,
  input  logic        uart_parity_err,
  input  logic        uart_framing_err,
  input  logic        uart_overflow,
  output logic        uart_csn,
  output logic        uart_oen,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  input  logic        pl_ready,
  output logic        pl_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [15:0] good_cnt,
  output logic [7:0]  err_cnt
);

  localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         DEPTH     = 1 << IW;
  localparam logic [7:0] c_max_len = 8'(MAX_LEN);

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_STB  = 2'd1;
  localparam logic [1:0] RD_LOW  = 2'd2;

  localparam logic [2:0] P_HUNT  = 3'd0;
  localparam logic [2:0] P_LEN   = 3'd1;
  localparam logic [2:0] P_PAY   = 3'd2;
  localparam logic [2:0] P_CHK   = 3'd3;
  localparam logic [2:0] P_DRAIN = 3'd4;

  logic [1:0]  r_rd_state, w_rd_next;
  logic [2:0]  r_ps, w_ps_next;
  logic        r_byte_vld, r_perr, r_ferr;
  logic [7:0]  r_byte;
  logic [7:0]  r_len, r_sum, r_idx, r_rd_idx;
  logic [7:0]  r_buf [DEPTH];
  logic        r_pl_valid, r_pl_last, r_frame_ok, r_frame_err;
  logic [7:0]  r_pl_data, r_err_cnt;
  logic [2:0]  r_err_code;
  logic [15:0] r_good_cnt;
  logic        w_line_err, w_in_frame, w_abort, w_ok, w_timeout;
  logic [2:0]  w_code;
  logic [7:0]  w_chk_sum, w_len_m1, w_rd_inc;

  assign w_line_err = r_perr | r_ferr;
  assign w_in_frame = (r_ps == P_LEN) || (r_ps == P_PAY) || (r_ps == P_CHK);
  assign w_chk_sum  = r_sum + r_byte;
  assign w_len_m1   = r_len - 8'd1;
  assign w_rd_inc   = r_rd_idx + 8'd1;

  // Read FSM: one CSN/OEN strobe per RXRDY assertion, blocked while draining
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_rd_state <= RD_IDLE;
    else          r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (uart_rxrdy && (r_ps != P_DRAIN)) w_rd_next = RD_STB;
      RD_STB:  w_rd_next = RD_LOW;
      RD_LOW:  if (!uart_rxrdy) w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    uart_csn = 1'b1;
    uart_oen = 1'b1;
    if (r_rd_state == RD_STB) begin
      uart_csn = 1'b0;
      uart_oen = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_byte_vld <= 1'b0;
      r_byte     <= 8'd0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_byte_vld <= (r_rd_state == RD_STB);
      if (r_rd_state == RD_STB) begin
        r_byte <= uart_data;
        r_perr <= uart_parity_err;
        r_ferr <= uart_framing_err;
      end
    end
  end

`ifdef CORE_UART_FRAME_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                       r_to_cnt <= 16'd0;
    else if (r_byte_vld || !w_in_frame) r_to_cnt <= 16'd0;
    else                                r_to_cnt <= r_to_cnt + 16'd1;
  end
  assign w_timeout = w_in_frame && (r_to_cnt >= 16'(TIMEOUT_CYC));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign w_timeout        = 1'b0;
`endif

  // Parser FSM
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_ps <= P_HUNT;
    else          r_ps <= w_ps_next;
  end

  always_comb begin
    w_ps_next = r_ps;
    case (r_ps)
      P_HUNT:  if (r_byte_vld && !w_line_err && (r_byte == SOF_BYTE)) w_ps_next = P_LEN;
      P_LEN:   if (w_abort) w_ps_next = P_HUNT;
               else if (r_byte_vld) w_ps_next = P_PAY;
      P_PAY:   if (w_abort) w_ps_next = P_HUNT;
               else if (r_byte_vld && (r_idx == w_len_m1)) w_ps_next = P_CHK;
      P_CHK:   if (w_abort) w_ps_next = P_HUNT;
               else if (w_ok) w_ps_next = P_DRAIN;
      P_DRAIN: if (r_pl_valid && pl_ready && r_pl_last) w_ps_next = P_HUNT;
      default: w_ps_next = P_HUNT;
    endcase
  end

  // Abort priority: overflow, line error, LEN/CHK check, timeout
  always_comb begin
    w_abort = 1'b0;
    w_ok    = 1'b0;
    w_code  = 3'd0;
    if (w_in_frame && uart_overflow) begin
      w_abort = 1'b1;
      w_code  = 3'd4;
    end else if (w_in_frame && r_byte_vld && w_line_err) begin
      w_abort = 1'b1;
      w_code  = 3'd1;
    end else if ((r_ps == P_LEN) && r_byte_vld &&
                 ((r_byte == 8'd0) || (r_byte > c_max_len))) begin
      w_abort = 1'b1;
      w_code  = 3'd2;
    end else if ((r_ps == P_CHK) && r_byte_vld) begin
      if (w_chk_sum == 8'h00) begin
        w_ok = 1'b1;
      end else begin
        w_abort = 1'b1;
        w_code  = 3'd3;
      end
    end else if (w_timeout && !r_byte_vld) begin
      w_abort = 1'b1;
      w_code  = 3'd5;
    end
  end

  always_ff @(posedge CLK) begin
    if ((r_ps == P_PAY) && r_byte_vld && !w_abort) r_buf[r_idx[IW-1:0]] <= r_byte;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_len       <= 8'd0;
      r_sum       <= 8'd0;
      r_idx       <= 8'd0;
      r_rd_idx    <= 8'd0;
      r_pl_valid  <= 1'b0;
      r_pl_last   <= 1'b0;
      r_pl_data   <= 8'd0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 3'd0;
      r_err_cnt   <= 8'd0;
      r_good_cnt  <= 16'd0;
    end else begin
      r_frame_ok  <= w_ok;
      r_frame_err <= w_abort;
      if (w_abort) begin
        r_err_code <= w_code;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_ok && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
      if (r_byte_vld && !w_abort) begin
        if (r_ps == P_LEN) begin
          r_len <= r_byte;
          r_sum <= r_byte;
          r_idx <= 8'd0;
        end else if (r_ps == P_PAY) begin
          r_idx <= r_idx + 8'd1;
          r_sum <= w_chk_sum;
        end
      end
      if (w_ok) r_rd_idx <= 8'd0;
      // Output register loads on entry to DRAIN, then advances per handshake
      if (r_ps == P_DRAIN) begin
        if (!r_pl_valid) begin
          r_pl_valid <= 1'b1;
          r_pl_data  <= r_buf[r_rd_idx[IW-1:0]];
          r_pl_last  <= (r_rd_idx == w_len_m1);
        end else if (pl_ready) begin
          if (r_pl_last) begin
            r_pl_valid <= 1'b0;
            r_pl_last  <= 1'b0;
          end else begin
            r_rd_idx  <= w_rd_inc;
            r_pl_data <= r_buf[w_rd_inc[IW-1:0]];
            r_pl_last <= (w_rd_inc == w_len_m1);
          end
        end
      end
    end
  end

  assign pl_data   = r_pl_data;
  assign pl_valid  = r_pl_valid;
  assign pl_last   = r_pl_last;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign good_cnt  = r_good_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_core_uart_frame_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_core_uart_frame_rx : directed + random frames against a frame-level model.
// Rev 1.0
//------------------------------------------------------------------------------
module tb_core_uart_frame_rx;
  localparam int MAX_LEN = 16;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        uart_rxrdy = 1'b0;
  logic [7:0]  uart_data = 8'd0;
  logic        uart_parity_err = 1'b0;
  logic        uart_framing_err = 1'b0;
  logic        uart_overflow = 1'b0;
  logic        uart_csn, uart_oen;
  logic [7:0]  pl_data;
  logic        pl_valid, pl_last;
  logic        pl_ready = 1'b1;
  logic        frame_ok, frame_err;
  logic [2:0]  err_code;
  logic [15:0] good_cnt;
  logic [7:0]  err_cnt;

  always #5 CLK = ~CLK;

  core_uart_frame_rx #(.MAX_LEN(MAX_LEN), .SOF_BYTE(8'hA5), .TIMEOUT_CYC(50)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .uart_rxrdy(uart_rxrdy), .uart_data(uart_data),
    .uart_parity_err(uart_parity_err), .uart_framing_err(uart_framing_err),
    .uart_overflow(uart_overflow), .uart_csn(uart_csn), .uart_oen(uart_oen),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_last(pl_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Observed activity
  int         n_ok_seen = 0, n_err_seen = 0, n_last_seen = 0;
  logic [7:0] got_pl[$];
  always @(negedge CLK) begin
    #1;
    if (frame_ok)  n_ok_seen++;
    if (frame_err) n_err_seen++;
    if (pl_valid && pl_ready) begin
      got_pl.push_back(pl_data);
      if (pl_last) n_last_seen++;
    end
  end

  // Frame-level reference model
  int         exp_ok = 0, exp_err = 0, exp_good = 0, exp_errc = 0, pl_ptr = 0;
  logic [2:0] exp_code = 3'd0;
  logic [7:0] exp_pl[$];
  logic [7:0] tx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_good();
    exp_ok++;
    exp_good++;
    for (int i = 2; i < tx_q.size() - 1; i++) exp_pl.push_back(tx_q[i]);
  endtask

  task automatic model_err(input logic [2:0] code);
    exp_err++;
    if (exp_errc < 255) exp_errc++;
    exp_code = code;
  endtask

  task automatic build_frame(input int len);
    logic [7:0] s, b;
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'(len));
    s = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
      s = s + b;
    end
    tx_q.push_back(8'h00 - s);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic pe, input logic fe);
    logic got;
    got = 1'b0;
    @(negedge CLK);
    uart_data = d; uart_parity_err = pe; uart_framing_err = fe; uart_rxrdy = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge CLK);
      if (uart_csn == 1'b0) got = 1'b1;
    end
    uart_rxrdy = 1'b0;
    chk("rd_strobe", 32'(got), 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    uart_parity_err = 1'b0; uart_framing_err = 1'b0;
  endtask

  task automatic send_q(input int bad_at, input logic use_fe);
    for (int i = 0; i < tx_q.size(); i++)
      send_byte(tx_q[i], (i == bad_at) && !use_fe, (i == bad_at) && use_fe);
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got_pl.size()) return got_pl[i];
    return 8'hxx;
  endfunction

  task automatic check_all(input string tag);
    repeat (MAX_LEN + 10) @(negedge CLK);
    chk({tag, ":ok_pulses"}, 32'(n_ok_seen), 32'(exp_ok));
    chk({tag, ":err_pulses"}, 32'(n_err_seen), 32'(exp_err));
    chk({tag, ":err_code"}, 32'(err_code), 32'(exp_code));
    chk({tag, ":good_cnt"}, 32'(good_cnt), 32'(exp_good));
    chk({tag, ":err_cnt"}, 32'(err_cnt), 32'(exp_errc));
    chk({tag, ":last_cnt"}, 32'(n_last_seen), 32'(exp_ok));
    chk({tag, ":pl_count"}, 32'(got_pl.size()), 32'(exp_pl.size()));
    for (int i = pl_ptr; i < exp_pl.size(); i++)
      chk({tag, ":pl_data"}, 32'(got_at(i)), 32'(exp_pl[i]));
    pl_ptr = exp_pl.size();
    chk({tag, ":pl_valid_idle"}, 32'(pl_valid), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hold;
    logic       stable, csn_hi, got;
    int         len, kind, p;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst:good_cnt_in_reset", 32'(good_cnt), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("rst:uart_csn", 32'(uart_csn), 32'd1);
    chk("rst:uart_oen", 32'(uart_oen), 32'd1);
    chk("rst:pl_valid", 32'(pl_valid), 32'd0);
    chk("rst:pl_last", 32'(pl_last), 32'd0);
    chk("rst:pl_data", 32'(pl_data), 32'd0);
    chk("rst:frame_ok", 32'(frame_ok), 32'd0);
    chk("rst:frame_err", 32'(frame_err), 32'd0);
    chk("rst:err_code", 32'(err_code), 32'd0);
    chk("rst:err_cnt", 32'(err_cnt), 32'd0);

    // Basic good frame with latency checks on the CHK byte
    tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_q(-1, 1'b0);
    chk("t1:frame_ok_lat", 32'(frame_ok), 32'd1);
    chk("t1:pl_valid_after_ok", 32'(pl_valid), 32'd0);
    @(negedge CLK);
    chk("t1:pl_valid_rise", 32'(pl_valid), 32'd1);
    chk("t1:first_byte", 32'(pl_data), 32'h11);
    model_good();
    check_all("t1");

    // Bad checksum
    tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    send_q(-1, 1'b0);
    model_err(3'd3);
    check_all("t2");

    // Noise, zero LEN, then one-byte frame
    tx_q = {8'h00, 8'hA5, 8'h00};
    send_q(-1, 1'b0);
    model_err(3'd2);
    check_all("t3a");
    tx_q = {8'hA5, 8'h01, 8'h7F, 8'h80};
    send_q(-1, 1'b0);
    model_good();
    check_all("t3b");

    // Parity error on second payload byte, then parser must be hunting again
    tx_q = {8'hA5, 8'h03, 8'h11, 8'h22};
    send_q(3, 1'b0);
    model_err(3'd1);
    check_all("t4a");
    build_frame(MAX_LEN);
    send_q(-1, 1'b0);
    model_good();
    check_all("t4b");

    // Backpressure during drain with RXRDY pending
    pl_ready = 1'b0;
    tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_q(-1, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      if (pl_valid) got = 1'b1;
    end
    chk("t5:pl_valid_wait", 32'(got), 32'd1);
    hold = pl_data;
    stable = 1'b1;
    csn_hi = 1'b1;
    uart_data = 8'h5A;
    uart_rxrdy = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (pl_data !== hold || pl_valid !== 1'b1) stable = 1'b0;
      if (uart_csn !== 1'b1) csn_hi = 1'b0;
    end
    chk("t5:held_byte", 32'(hold), 32'h11);
    chk("t5:pl_stable", 32'(stable), 32'd1);
    chk("t5:csn_blocked", 32'(csn_hi), 32'd1);
    pl_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge CLK);
      if (uart_csn == 1'b0) got = 1'b1;
    end
    uart_rxrdy = 1'b0;
    chk("t5:read_after_drain", 32'(got), 32'd1);
    model_good();
    check_all("t5");

`ifdef CORE_UART_FRAME_TIMEOUT_EN
    tx_q = {8'hA5, 8'h02, 8'h11};
    send_q(-1, 1'b0);
    repeat (60) @(negedge CLK);
    model_err(3'd5);
    check_all("t6");
`endif

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        hold = 8'($urandom);
        if (hold == 8'hA5) hold = 8'h00;
        send_byte(hold, 1'($urandom), 1'b0);
      end
      len  = $urandom_range(1, MAX_LEN);
      kind = $urandom_range(0, 4);
      build_frame(len);
      case (kind)
        1: begin
          tx_q.delete();
          tx_q.push_back(8'hA5);
          tx_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
          send_q(-1, 1'b0);
          model_err(3'd2);
        end
        2: begin
          tx_q[tx_q.size() - 1] = tx_q[tx_q.size() - 1] ^ 8'($urandom_range(1, 255));
          send_q(-1, 1'b0);
          model_err(3'd3);
        end
        3: begin
          p = $urandom_range(1, len + 1);
          while (tx_q.size() > p + 1) tx_q.pop_back();
          send_q(p, 1'($urandom_range(0, 1)));
          model_err(3'd1);
        end
        4: begin
          p = $urandom_range(1, len + 1);
          while (tx_q.size() > p) tx_q.pop_back();
          send_q(-1, 1'b0);
          @(negedge CLK); uart_overflow = 1'b1;
          @(negedge CLK); uart_overflow = 1'b0;
          model_err(3'd4);
        end
        default: begin
          send_q(-1, 1'b0);
          model_good();
        end
      endcase
      check_all("rand");
    end

    // Reset mid-frame: everything clears, no pulses
    tx_q = {8'hA5, 8'h03, 8'h11};
    send_q(-1, 1'b0);
    @(negedge CLK); RESET_N = 1'b0;
    @(negedge CLK);
    chk("t7:good_cnt_rst", 32'(good_cnt), 32'd0);
    chk("t7:err_cnt_rst", 32'(err_cnt), 32'd0);
    chk("t7:err_code_rst", 32'(err_code), 32'd0);
    @(negedge CLK); RESET_N = 1'b1;
    exp_good = 0; exp_errc = 0; exp_code = 3'd0;
    build_frame(5);
    send_q(-1, 1'b0);
    model_good();
    check_all("t7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_uart_frame_rx.md
# core_uart_frame_rx

Framed-packet receiver sitting directly downstream of the CoreUART receive path. It pulls bytes out of the UART core through the core's CSN/OEN read strobe whenever RXRDY is high, then parses frames of the form SOF, LEN, payload, CHK. Each payload is buffered and released on a valid/ready stream only after the checksum passes. Malformed or corrupted frames are discarded and reported.

## Interface
- MAX_LEN, 16: maximum payload bytes per frame (1..255); buffer depth.
- SOF_BYTE, 8'hA5: start-of-frame marker.
- TIMEOUT_CYC, 1000: inter-byte timeout in CLK cycles (only with timeout compiled in).
- CLK  in  1  system clock, same as UART core CLK.
- RESET_N  in  1  asynchronous active-low reset.
- uart_rxrdy  in  1  UART core RXRDY.
- uart_data  in  8  UART core DATA_OUT.
- uart_parity_err  in  1  UART core PARITY_ERR.
- uart_framing_err  in  1  UART core FRAMING_ERR.
- uart_overflow  in  1  UART core OVERFLOW.
- uart_csn  out  1  UART core CSN, active low.
- uart_oen  out  1  UART core OEN, active low.
- pl_data  out  8  payload byte.
- pl_valid  out  1  pl_data valid.
- pl_ready  in  1  downstream accepts pl_data.
- pl_last  out  1  marks final payload byte.
- frame_ok  out  1  one-cycle pulse when a frame passes its checks.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- err_code  out  3  1=line error, 2=bad LEN, 3=bad CHK, 4=overflow, 5=timeout. Held until the next frame_err.
- good_cnt  out  16  good frames, saturating.
- err_cnt  out  8  aborted frames, saturating.

## Operation
- Reset values: uart_csn=1, uart_oen=1, pl_valid=0, pl_last=0, pl_data=0, frame_ok=0, frame_err=0, err_code=0, good_cnt=0, err_cnt=0. Both FSMs start in their first state.
- Read FSM:
  - RD_IDLE: if uart_rxrdy=1 and the parser is not in DRAIN, go to RD_STB.
  - RD_STB (exactly 1 cycle): uart_csn=0 and uart_oen=0. Capture uart_data, uart_parity_err and uart_framing_err in this cycle. Go to RD_LOW.
  - RD_LOW: wait until uart_rxrdy is sampled 0, then return to RD_IDLE. This prevents double-reads while RXRDY is falling.
- The captured byte is presented to the parser as byte_vld the cycle after RD_STB.
- Parser FSM (advances only on byte_vld unless noted):
  - HUNT: byte equal to SOF_BYTE goes to LEN; any other byte is dropped silently with no error.
  - LEN: 0 or >MAX_LEN aborts with code 2. Otherwise store LEN, set sum=LEN, idx=0, go to PAYLOAD.
  - PAYLOAD: write byte to buf[idx], idx++, sum+=byte (mod 256). When idx==LEN go to CHK.
  - CHK: sum+byte==8'h00 pulses frame_ok, good_cnt++, go to DRAIN with rd_idx=0. Otherwise abort with code 3.
  - DRAIN: pl_valid=1, pl_data=buf[rd_idx], pl_last=(rd_idx==LEN-1). On pl_valid&pl_ready, rd_idx++. After the last byte handshake, go to HUNT.
- Abort: pulse frame_err, update err_code, err_cnt++, go to HUNT. The buffer content is ignored.
- A line error (captured parity or framing flag set) in any state except HUNT and DRAIN aborts with code 1. In HUNT the byte is dropped. Line error wins over LEN/CHK checks on the same byte.
- uart_overflow=1 in LEN/PAYLOAD/CHK aborts with code 4, independent of byte_vld. Overflow outranks a line error in the same cycle.
- No UART reads occur during DRAIN. Backpressure is passed to the UART core and its FIFO; overflow there is reported on the next frame.

## Timing
- RXRDY high to strobe: 1 cycle. Strobe to parser update: 1 cycle.
- CHK byte strobe to frame_ok: 2 cycles. pl_valid rises in the cycle after frame_ok.
- Drain throughput: 1 byte per cycle while pl_ready=1. pl_data/pl_last hold while pl_valid&!pl_ready.
- Minimum byte spacing: 3 cycles (strobe, then RXRDY low, then idle).
- Reset mid-frame or mid-drain: all state and counters clear immediately; no pulses are produced.

## Configuration
- CORE_UART_FRAME_TIMEOUT_EN defined: a 16-bit counter clears on every byte_vld and counts in LEN/PAYLOAD/CHK. Reaching TIMEOUT_CYC aborts with code 5. The counter is idle in HUNT and DRAIN.
- Not defined: no counter is built; frames never time out and code 5 never appears.

## Test plan
- Bytes A5 03 11 22 33 97 with pl_ready=1 -> frame_ok once; pl_data 11,22,33; pl_last on 33; good_cnt=1.
- Same frame with CHK=98 -> frame_err, err_code=3, no pl_valid, err_cnt=1.
- Bytes 00 A5 00 -> 00 ignored; then frame_err with err_code=2. Following A5 01 7F 80 -> pl_data 7F.
- Parity error asserted on the second payload byte of a LEN=3 frame -> frame_err with code 1; parser back in HUNT.
- With the timeout macro defined and TIMEOUT_CYC=50: send A5 02 11, then stall 60 cycles -> frame_err with code 5.
- pl_ready held low for 20 cycles during drain -> pl_data stable; uart_csn stays 1 while RXRDY=1; completes after release.
